// File: rtl/pp_accum_512.sv
// pp_accum_512: sequences A digits into a 16x256 multiplier and accumulates partial products into a 512-bit product
module pp_accum_512 (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] a,
  output logic [15:0]  digit,
  output logic [3:0]   digit_idx,
  output logic         digit_valid,
  input  logic         digit_ready,
  input  logic [271:0] pp,
  input  logic         pp_valid,
  output logic [511:0] product,
  output logic         busy,
  output logic         done,
  output logic         proto_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [255:0] a_q, a_d, acc_hi_q, acc_hi_d, lo_q, lo_d;
  logic [3:0] idx_q, idx_d;
  logic [511:0] product_q, product_d;
  logic proto_err_q, proto_err_d;
  logic [271:0] sum;
  // next-state, digit sequencing and shifted accumulate of each partial product
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    idx_d = idx_q;
    acc_hi_d = acc_hi_q;
    lo_d = lo_q;
    product_d = product_q;
    proto_err_d = proto_err_q | (pp_valid && state_q != WAIT);
    sum = {16'b0, acc_hi_q} + pp;
    case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        a_d = a;
        idx_d = 4'd0;
        acc_hi_d = '0;
        lo_d = '0;
        proto_err_d = 1'b0;
      end
      REQ: state_d = digit_ready ? WAIT : REQ;
      WAIT: if (pp_valid) begin
        lo_d[{idx_q, 4'b0} +: 16] = sum[15:0];
        acc_hi_d = sum[271:16];
        state_d = (idx_q == 4'd15) ? DONE : REQ;
        idx_d = (idx_q == 4'd15) ? idx_q : idx_q + 4'd1;
        product_d = (idx_q == 4'd15) ? {sum[271:16], sum[15:0], lo_q[239:0]} : product_q;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // state registers, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q <= '0;
      idx_q <= '0;
      acc_hi_q <= '0;
      lo_q <= '0;
      product_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      idx_q <= idx_d;
      acc_hi_q <= acc_hi_d;
      lo_q <= lo_d;
      product_q <= product_d;
      proto_err_q <= proto_err_d;
    end
  end
  assign digit = a_q[{idx_q, 4'b0} +: 16];
  assign digit_idx = idx_q;
  assign digit_valid = state_q == REQ;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign product = product_q;
  assign proto_err = proto_err_q;
endmodule

// File: tb/tb_pp_accum_512.sv
// tb_pp_accum_512: directed and randomized-stall checks of the 256x256 digit-serial multiplier sequencer
module tb_pp_accum_512;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, digit_ready = 1'b0, pp_valid = 1'b0;
  logic [255:0] a = '0;
  logic [271:0] pp = '0;
  logic [15:0] digit;
  logic [3:0] digit_idx;
  logic digit_valid, busy, done, proto_err;
  logic [511:0] product;
  logic [255:0] ones = {256{1'b1}};
  logic [255:0] ra, rb;
  int total = 0, bad = 0;

  pp_accum_512 dut (
    .clk(clk), .reset(reset), .start(start), .a(a),
    .digit(digit), .digit_idx(digit_idx), .digit_valid(digit_valid), .digit_ready(digit_ready),
    .pp(pp), .pp_valid(pp_valid), .product(product), .busy(busy), .done(done), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digit"}, digit, 0);
    check({tag, "_idx"}, digit_idx, 0);
    check({tag, "_dvalid"}, digit_valid, 0);
    check({tag, "_product"}, product, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_perr"}, proto_err, 0);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // drives one multiplication, acting as the upstream 16x256 multiplier with optional stalls
  task automatic run_op(input logic [255:0] av, input logic [255:0] bv, input logic [511:0] exp,
                        input int max_rs, input int max_pd, input int bad_k, input int abort_k,
                        input bit mid_start, input bit exp_perr);
    int cyc, extra, rs, pd;
    logic [15:0] w;
    extra = 0;
    start = 1'b1;
    a = av;
    @(negedge clk);
    start = 1'b0;
    a = ~av;
    cyc = 1;
    check("busy_after_start", busy, 1);
    check("perr_cleared", proto_err, 0);
    for (int k = 0; k < 16; k++) begin
      w = av[16*k +: 16];
      rs = $urandom_range(max_rs);
      for (int s = 0; s <= rs; s++) begin
        check("req_dvalid", digit_valid, 1);
        check("req_idx", digit_idx, k[3:0]);
        check("req_digit", digit, w);
        if (k == bad_k && s == 0) begin
          pp_valid = 1'b1;
          pp = {16'hdead, rnd256()};
        end
        if (mid_start && cyc == 10) begin
          start = 1'b1;
          a = ones;
        end
        digit_ready = (s == rs);
        @(negedge clk);
        cyc++;
        pp_valid = 1'b0;
        start = 1'b0;
        digit_ready = 1'b0;
      end
      extra += rs;
      pd = $urandom_range(max_pd);
      for (int s = 0; s <= pd; s++) begin
        check("wait_dvalid", digit_valid, 0);
        if (k == abort_k) begin
          reset = 1'b0;
          #1;
          check_reset_outputs("abort");
          @(negedge clk);
          reset = 1'b1;
          @(negedge clk);
          return;
        end
        if (mid_start && cyc == 10) begin
          start = 1'b1;
          a = ones;
        end
        pp_valid = (s == pd);
        pp = {256'b0, w} * {16'b0, bv};
        @(negedge clk);
        cyc++;
        pp_valid = 1'b0;
        start = 1'b0;
      end
      extra += pd;
    end
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("product", product, exp);
    check("done_perr", proto_err, exp_perr);
    check("latency", cyc, 33 + extra);
    @(negedge clk);
    check("done_drop", done, 0);
    check("busy_drop", busy, 0);
    check("product_hold", product, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    run_op(256'd1, ones, {256'b0, ones}, 0, 0, -1, -1, 1'b0, 1'b0);
    run_op(ones, ones, {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1}, 0, 0, -1, -1, 1'b0, 1'b0);
    run_op(256'd3, 256'd5, 512'd15, 2, 2, 3, -1, 1'b0, 1'b1);
    run_op(256'd7, 256'd9, 512'd63, 0, 0, -1, -1, 1'b1, 1'b0);
    run_op(ones, ones, '0, 0, 0, -1, 7, 1'b0, 1'b0);
    run_op(256'h1234, 256'h5678, 512'h06260060, 0, 0, -1, -1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      ra = rnd256();
      rb = rnd256();
      run_op(ra, rb, {256'b0, ra} * {256'b0, rb}, 5, 4, -1, -1, 1'b0, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
